// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage:
// funct3 load/store codes, access sizes and the request FSM states.
package mem_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_t;

    // Unlisted funct3 codes on a memory op behave as word accesses.
    function automatic mem_size_t f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

    // Bytes are always aligned; halves need bit 0 clear; words need both clear.
    function automatic logic is_aligned(input mem_size_t sz,
                                        input logic [1:0] lo);
        case (sz)
            SZ_H:    return ~lo[0];
            SZ_W:    return lo == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_align_ext.sv
// Load data alignment and sign/zero extension.
// Purely combinational so a forwarding path can reuse it.
module load_align_ext
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    // Move the addressed byte lane to bit 0, then extend to 32 bits.
    always_comb begin
        shifted   = rdata >> {addr_lo, 3'b000};
        load_data = shifted;
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_data = {24'h0, shifted[7:0]};
            F3_HU:   load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: data-memory handshake, store lanes,
// load alignment and the MEM/WB pipeline register.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_mem,
    input  logic [31:0] alu_result_mem,
    input  logic [31:0] rs2_data_mem,
    input  logic [4:0]  rd_mem,
    input  logic        wb_reg_file_mem,
    input  logic        memtoreg_mem,
    input  logic        mem_read_mem,
    input  logic        mem_write_mem,
    input  logic [2:0]  funct3_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        stall_mem,
    output logic        misalign_exc,
    output logic        valid_wb,
    output logic [31:0] alu_result_wb,
    output logic [31:0] load_data_wb,
    output logic [4:0]  rd_wb,
    output logic        wb_reg_file_wb,
    output logic        memtoreg_wb
);

    mem_state_t  state;
    mem_state_t  state_nx;
    mem_size_t   size;
    logic        mem_op;
    logic        is_store;
    logic        is_load;
    logic        aligned;
    logic        misaligned;
    logic        go;
    logic        complete;
    logic [3:0]  be_raw;
    logic [31:0] wdata_raw;
    logic [31:0] ext_data;

    // Classify the instruction in the EX/MEM slot.
    always_comb begin
        size       = f3_size(funct3_mem);
        mem_op     = valid_mem & (mem_read_mem | mem_write_mem);
        is_store   = mem_write_mem;
        is_load    = mem_read_mem & ~mem_write_mem;
        aligned    = is_aligned(size, alu_result_mem[1:0]);
        misaligned = mem_op & ~aligned;
        // No new request may start while reset is held.
        go         = mem_op & aligned & ~rst;
    end

    // Replicate store data across lanes and pick byte enables.
    always_comb begin
        wdata_raw = rs2_data_mem;
        be_raw    = 4'b1111;
        case (size)
            SZ_B: begin
                wdata_raw = {4{rs2_data_mem[7:0]}};
                be_raw    = 4'b0001 << alu_result_mem[1:0];
            end
            SZ_H: begin
                wdata_raw = {2{rs2_data_mem[15:0]}};
                be_raw    = alu_result_mem[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_raw = rs2_data_mem;
                be_raw    = 4'b1111;
            end
        endcase
    end

    // Request FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, request and stall decode.
    always_comb begin
        state_nx  = state;
        dmem_req  = 1'b0;
        stall_mem = 1'b0;
        unique case (state)
            IDLE: begin
                if (go) begin
                    dmem_req = 1'b1;
                    if (!dmem_ready) begin
                        stall_mem = 1'b1;
                        state_nx  = WAIT;
                    end
                end
            end
            WAIT: begin
                // Upstream is frozen, so the inputs still describe this access.
                dmem_req  = 1'b1;
                stall_mem = ~dmem_ready;
                if (dmem_ready) begin
                    state_nx = IDLE;
                end
            end
        endcase
    end

    // Drive the memory port from the current access.
    always_comb begin
        dmem_we    = dmem_req & is_store;
        dmem_addr  = {alu_result_mem[31:2], 2'b00};
        dmem_wdata = wdata_raw;
        dmem_be    = (dmem_req & is_store) ? be_raw : 4'b0000;
        complete   = dmem_req & dmem_ready;
    end

    load_align_ext u_load_align_ext (
        .rdata     (dmem_rdata),
        .addr_lo   (alu_result_mem[1:0]),
        .funct3    (funct3_mem),
        .load_data (ext_data)
    );

    // MEM/WB register; stalls and misaligned ops insert bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_wb       <= 1'b0;
            alu_result_wb  <= '0;
            load_data_wb   <= '0;
            rd_wb          <= '0;
            wb_reg_file_wb <= 1'b0;
            memtoreg_wb    <= 1'b0;
        end else if (stall_mem) begin
            valid_wb       <= 1'b0;
            wb_reg_file_wb <= 1'b0;
        end else begin
            valid_wb       <= valid_mem & ~misaligned;
            alu_result_wb  <= alu_result_mem;
            load_data_wb   <= (is_load & complete) ? ext_data : '0;
            rd_wb          <= rd_mem;
            wb_reg_file_wb <= wb_reg_file_mem & valid_mem & ~misaligned;
            memtoreg_wb    <= memtoreg_mem;
        end
    end

    // One-cycle exception pulse; a misaligned op never stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_exc <= 1'b0;
        end else begin
            misalign_exc <= misaligned & (state == IDLE);
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus random
// instructions checked against a transaction-level model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_mem;
    logic [31:0] alu_result_mem;
    logic [31:0] rs2_data_mem;
    logic [4:0]  rd_mem;
    logic        wb_reg_file_mem;
    logic        memtoreg_mem;
    logic        mem_read_mem;
    logic        mem_write_mem;
    logic [2:0]  funct3_mem;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        stall_mem;
    logic        misalign_exc;
    logic        valid_wb;
    logic [31:0] alu_result_wb;
    logic [31:0] load_data_wb;
    logic [4:0]  rd_wb;
    logic        wb_reg_file_wb;
    logic        memtoreg_wb;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .valid_mem       (valid_mem),
        .alu_result_mem  (alu_result_mem),
        .rs2_data_mem    (rs2_data_mem),
        .rd_mem          (rd_mem),
        .wb_reg_file_mem (wb_reg_file_mem),
        .memtoreg_mem    (memtoreg_mem),
        .mem_read_mem    (mem_read_mem),
        .mem_write_mem   (mem_write_mem),
        .funct3_mem      (funct3_mem),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_be         (dmem_be),
        .dmem_rdata      (dmem_rdata),
        .dmem_ready      (dmem_ready),
        .stall_mem       (stall_mem),
        .misalign_exc    (misalign_exc),
        .valid_wb        (valid_wb),
        .alu_result_wb   (alu_result_wb),
        .load_data_wb    (load_data_wb),
        .rd_wb           (rd_wb),
        .wb_reg_file_wb  (wb_reg_file_wb),
        .memtoreg_wb     (memtoreg_wb)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rdata,
                                             input logic [1:0] off,
                                             input logic [2:0] f3);
        int          sz;
        logic [31:0] v;
        sz = size_of(f3);
        v  = rdata >> (8 * off);
        if (sz == 1) begin
            v = v & 32'h0000_00FF;
            if (f3 == 3'b000 && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'h0000_FFFF;
            if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic set_idle_inputs();
        valid_mem       = 1'b0;
        alu_result_mem  = '0;
        rs2_data_mem    = '0;
        rd_mem          = '0;
        wb_reg_file_mem = 1'b0;
        memtoreg_mem    = 1'b0;
        mem_read_mem    = 1'b0;
        mem_write_mem   = 1'b0;
        funct3_mem      = '0;
        dmem_rdata      = '0;
        dmem_ready      = 1'b0;
    endtask

    task automatic chk_wb_zero(input string tag);
        chk1({tag, "_valid"}, valid_wb, 1'b0);
        chk32({tag, "_alu"}, alu_result_wb, 32'h0);
        chk32({tag, "_load"}, load_data_wb, 32'h0);
        chk32({tag, "_rd"}, {27'h0, rd_wb}, 32'h0);
        chk1({tag, "_rf"}, wb_reg_file_wb, 1'b0);
        chk1({tag, "_m2r"}, memtoreg_wb, 1'b0);
        chk1({tag, "_exc"}, misalign_exc, 1'b0);
    endtask

    // Called just after a rising edge; holds the instruction for 1+waits cycles.
    task automatic run_instr(input logic v, input logic [31:0] addr,
                             input logic [31:0] rs2, input logic [4:0] rd,
                             input logic rf, input logic m2r,
                             input logic ld, input logic st,
                             input logic [2:0] f3, input logic [31:0] rdata,
                             input int waits);
        int          sz;
        int          bem;
        int          nw;
        logic        is_mem;
        logic        mis;
        logic        go;
        logic        is_ld;
        logic        last;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] ld_exp;
        sz     = size_of(f3);
        is_mem = v && (ld || st);
        mis    = is_mem && ((addr % sz) != 0);
        go     = is_mem && !mis;
        is_ld  = ld && !st;
        bem    = ((1 << sz) - 1) << addr[1:0];
        be     = st ? bem[3:0] : 4'h0;
        if (sz == 1)      wd = 32'(rs2[7:0]) * 32'h0101_0101;
        else if (sz == 2) wd = 32'(rs2[15:0]) * 32'h0001_0001;
        else              wd = rs2;
        ld_exp = ref_load(rdata, addr[1:0], f3);
        nw     = go ? waits : 0;

        valid_mem       = v;
        alu_result_mem  = addr;
        rs2_data_mem    = rs2;
        rd_mem          = rd;
        wb_reg_file_mem = rf;
        memtoreg_mem    = m2r;
        mem_read_mem    = ld;
        mem_write_mem   = st;
        funct3_mem      = f3;
        for (int c = 0; c <= nw; c++) begin
            last       = (c == nw);
            dmem_ready = go ? last : 1'($urandom);
            dmem_rdata = (go && last) ? rdata : $urandom;
            @(negedge clk);
            chk1("req", dmem_req, go);
            chk1("stall", stall_mem, go && !last);
            if (go) begin
                chk32("addr", dmem_addr, addr & ~32'h3);
                chk1("we", dmem_we, st);
                chk32("be", {28'h0, dmem_be}, {28'h0, be});
                if (st) chk32("wdata", dmem_wdata, wd);
            end
            @(posedge clk);
            #1;
            if (!last) begin
                chk1("bubble_valid", valid_wb, 1'b0);
                chk1("bubble_rf", wb_reg_file_wb, 1'b0);
                chk1("exc_wait", misalign_exc, 1'b0);
            end else begin
                chk1("valid_wb", valid_wb, v && !mis);
                chk1("rf_wb", wb_reg_file_wb, rf && v && !mis);
                chk1("exc", misalign_exc, mis);
                if (v && !mis) begin
                    chk32("alu_wb", alu_result_wb, addr);
                    chk32("rd_wb", {27'h0, rd_wb}, {27'h0, rd});
                    chk1("m2r_wb", memtoreg_wb, m2r);
                    chk32("load_wb", load_data_wb, is_ld ? ld_exp : 32'h0);
                end
            end
        end
    endtask

    initial begin
        logic        v;
        logic        ld;
        logic        st;
        logic [31:0] addr;
        int          kind;

        rst = 1'b1;
        set_idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk_wb_zero("reset");
        chk1("reset_req", dmem_req, 1'b0);
        chk1("reset_stall", stall_mem, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // LB sign-extends 0x80 from the top lane.
        run_instr(1, 32'h0000_1003, 32'h0, 5'd3, 1, 1, 1, 0,
                  3'b000, 32'h80FF_1234, 0);
        chk32("lb_const", load_data_wb, 32'hFFFF_FF80);
        // SH to the upper half.
        run_instr(1, 32'h0000_2002, 32'hDEAD_BEEF, 5'd0, 0, 0, 0, 1,
                  3'b001, 32'h0, 0);
        // LW with three wait cycles.
        run_instr(1, 32'h0000_3000, 32'h0, 5'd7, 1, 1, 1, 0,
                  3'b010, 32'hCAFE_F00D, 3);
        chk32("lw_const", load_data_wb, 32'hCAFE_F00D);
        // Misaligned LH followed by an ALU op.
        run_instr(1, 32'h0000_4001, 32'h0, 5'd9, 1, 1, 1, 0,
                  3'b001, 32'h0, 0);
        run_instr(1, 32'h0000_0042, 32'h0, 5'd10, 1, 0, 0, 0,
                  3'b000, 32'h0, 0);

        // Reset while waiting on a load.
        valid_mem       = 1'b1;
        alu_result_mem  = 32'h0000_6000;
        rd_mem          = 5'd11;
        wb_reg_file_mem = 1'b1;
        memtoreg_mem    = 1'b1;
        mem_read_mem    = 1'b1;
        mem_write_mem   = 1'b0;
        funct3_mem      = 3'b010;
        dmem_ready      = 1'b0;
        @(posedge clk);
        #1;
        chk1("wait_stall", stall_mem, 1'b1);
        chk1("wait_req", dmem_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("rst_req", dmem_req, 1'b0);
        chk1("rst_stall", stall_mem, 1'b0);
        chk_wb_zero("rst_wait");
        set_idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // Back-to-back LBU then ADD.
        run_instr(1, 32'h0000_5001, 32'h0, 5'd12, 1, 1, 1, 0,
                  3'b100, 32'h1234_FF00, 0);
        chk32("lbu_const", load_data_wb, 32'h0000_00FF);
        run_instr(1, 32'h0000_1234, 32'h0, 5'd13, 1, 0, 0, 0,
                  3'b000, 32'h0, 0);

        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 3));
            v    = ($urandom_range(0, 7) != 0);
            ld   = (kind == 1) || (kind == 3);
            st   = (kind == 2) || (kind == 3);
            addr = $urandom;
            if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
            run_instr(v, addr, $urandom, 5'($urandom),
                      v ? 1'($urandom) : 1'b0, 1'($urandom), ld, st,
                      3'($urandom), $urandom, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, between the EX/MEM register and the writeback stage. It issues loads and stores to the data memory over a req/ready handshake, produces byte enables and replicated store data, and aligns and extends load data. It also owns the MEM/WB pipeline register that drives the writeback stage's inputs. It stalls upstream while a memory access is outstanding.

## Interface
- No parameters; XLEN fixed at 32.
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- valid_mem  in  1  EX/MEM slot holds a real instruction
- alu_result_mem  in  32  effective address or ALU result
- rs2_data_mem  in  32  store data
- rd_mem  in  5  destination register
- wb_reg_file_mem  in  1  RegWrite
- memtoreg_mem  in  1  load result selects memory data
- mem_read_mem  in  1  load
- mem_write_mem  in  1  store
- funct3_mem  in  3  access size/sign
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  store data, lane-replicated
- dmem_be  out  4  byte enables (0 on loads)
- dmem_rdata  in  32  read word, valid when dmem_ready
- dmem_ready  in  1  access completes this cycle
- stall_mem  out  1  hold EX/MEM and earlier stages
- misalign_exc  out  1  registered one-cycle pulse on misaligned access
- valid_wb, alu_result_wb[32], load_data_wb[32], rd_wb[5], wb_reg_file_wb, memtoreg_wb  out  MEM/WB register

## Operation
- funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU. Other codes with a memory op are treated as W.
- A memory op is valid_mem & (mem_read_mem | mem_write_mem). mem_write takes priority if both are set.
- Aligned: B always; H needs addr[0]=0; W needs addr[1:0]=0.
- Misaligned memory op:
  - no dmem_req;
  - misalign_exc=1 next cycle;
  - MEM/WB gets a bubble (valid_wb=0, wb_reg_file_wb=0);
  - no stall.
- Stores:
  - SB: wdata={4{rs2[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, be=addr[1]?1100:0011.
  - SW: wdata=rs2, be=1111.
- Loads: shift dmem_rdata right by 8*addr[1:0]. B/H sign-extend, BU/HU zero-extend, W passes through.
- FSM, 2 states:
  - IDLE: aligned memory op → dmem_req=1 combinationally.
    - dmem_ready=1 → complete in the same cycle, stay IDLE.
    - dmem_ready=0 → go to WAIT.
  - WAIT: dmem_req=1 and all dmem_* outputs held stable (upstream is stalled, so inputs are stable).
    - dmem_ready=1 → complete, go to IDLE.
- stall_mem = (IDLE & aligned mem op & !dmem_ready) | (WAIT & !dmem_ready). It is combinational from dmem_ready.
- MEM/WB register update on every clk edge:
  - stall_mem=1 → bubble (valid_wb=0, wb_reg_file_wb=0, other fields don't-care but hold).
  - else → valid_wb=valid_mem & !misaligned; fields copied from *_mem; load_data_wb = aligned/extended rdata (0 if not a load).
- Non-memory instruction: passes through in one cycle with no stall.

## Timing
- Latency: one cycle from EX/MEM to MEM/WB when memory responds in the request cycle. N extra cycles for N wait cycles.
- Reset (async assert, sync release):
  - state=IDLE;
  - all MEM/WB outputs 0;
  - misalign_exc=0.
- Reset asserted in WAIT abandons the request. dmem_req drops immediately because it is decoded from state and inputs.
- dmem_ready outside a request is ignored.
- dmem_ready in the same cycle as entry to IDLE with a new op completes that new op. There is no idle cycle between back-to-back accesses.
- misalign_exc is high exactly one cycle per offending instruction.

## Structure
- Shared package (pipeline package): funct3 load/store constants, mem_state_t enum {IDLE, WAIT}.
- Sub-module load_align_ext: combinational (rdata, addr[1:0], funct3) → 32-bit extended load data. It is reused by any future forwarding path.
- Store lane/byte-enable generation, the FSM and the MEM/WB register live in mem_stage.

## Test plan
- LB at addr 0x1003, rdata 0x80FF_1234, ready same cycle → load_data_wb=0xFFFFFF80, stall_mem never high, valid_wb=1 next cycle.
- SH at 0x2002, rs2=0xDEAD_BEEF → dmem_be=1100, dmem_wdata=0xBEEFBEEF, dmem_addr=0x2000, dmem_we=1.
- LW at 0x3000 with ready delayed 3 cycles → stall_mem=1 for 3 cycles, 3 bubbles into WB, then load_data_wb=rdata. dmem_addr is stable throughout.
- LH at 0x4001 → no dmem_req, misalign_exc pulses 1 cycle, valid_wb=0, wb_reg_file_wb=0.
- Reset asserted mid-WAIT → dmem_req=0 immediately, all WB outputs 0. After release a back-to-back LBU/ADD sequence completes (LBU 0xFF → 0x000000FF).
